// File: rtl/iob_reg.sv
// Library register cell: async active-low reset, clock enable.
// Reset value is set per instance.
module iob_reg #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic         cke_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o <= RST_VAL;
    end else if (cke_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_reg_e.sv
// Library register cell with load enable on top of cke.
// Async active-low reset to RST_VAL.
module iob_reg_e #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic         cke_i,
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o <= RST_VAL;
    end else if (cke_i && en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob2apb.sv
// IOb slave to APB master bridge: one registered request
// replayed as a SETUP/ACCESS transfer, read data returned on rvalid.
module iob2apb #(
  parameter int ADDR_W     = 21,
  parameter int DATA_W     = 32,
  parameter int APB_ADDR_W = ADDR_W,
  parameter int APB_DATA_W = DATA_W
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_n_i,
  input  logic                    iob_valid_i,
  input  logic [ADDR_W-1:0]       iob_addr_i,
  input  logic [DATA_W-1:0]       iob_wdata_i,
  input  logic [DATA_W/8-1:0]     iob_wstrb_i,
  output logic                    iob_ready_o,
  output logic                    iob_rvalid_o,
  output logic [DATA_W-1:0]       iob_rdata_o,
  output logic                    apb_sel_o,
  output logic                    apb_enable_o,
  output logic [APB_ADDR_W-1:0]   apb_addr_o,
  output logic [APB_DATA_W-1:0]   apb_wdata_o,
  output logic [APB_DATA_W/8-1:0] apb_wstrb_o,
  output logic                    apb_write_o,
  input  logic                    apb_ready_i,
  input  logic [APB_DATA_W-1:0]   apb_rdata_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              write;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
  } req_t;

  logic [1:0]  state_d, state_q;
  logic        ready_d, ready_q;
  logic        rvalid_d, rvalid_q;
  logic        sel_d, sel_q;
  logic        en_d, en_q;
  logic        accept;
  logic        rd_done;
  req_t        req_d, req_q;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rd_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        // ready_q gates acceptance so the first cycle after reset is idle
        if (iob_valid_i && ready_q) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb_ready_i) begin
          state_d = IDLE;
          rd_done = ~req_q.write;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d  = (state_d == IDLE);
    sel_d    = (state_d != IDLE);
    en_d     = (state_d == ACCESS);
    rvalid_d = rd_done;

    req_d.write = |iob_wstrb_i;
    req_d.wstrb = iob_wstrb_i;
    req_d.wdata = iob_wdata_i;
    req_d.addr  = iob_addr_i;
  end

  iob_reg #(.W(2), .RST_VAL(IDLE)) u_state (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .data_i   (state_d),
    .data_o   (state_q)
  );

  iob_reg #(.W(1), .RST_VAL(1'b0)) u_ready (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .data_i   (ready_d),
    .data_o   (ready_q)
  );

  iob_reg #(.W(1), .RST_VAL(1'b0)) u_rvalid (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .data_i   (rvalid_d),
    .data_o   (rvalid_q)
  );

  iob_reg #(.W(1), .RST_VAL(1'b0)) u_sel (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .data_i   (sel_d),
    .data_o   (sel_q)
  );

  iob_reg #(.W(1), .RST_VAL(1'b0)) u_en (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .data_i   (en_d),
    .data_o   (en_q)
  );

  iob_reg_e #(.W($bits(req_t)), .RST_VAL('0)) u_req (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .en_i     (accept),
    .data_i   (req_d),
    .data_o   (req_q)
  );

  iob_reg_e #(.W(DATA_W), .RST_VAL('0)) u_rdata (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .en_i     (rd_done),
    .data_i   (apb_rdata_i),
    .data_o   (rdata_q)
  );

  assign iob_ready_o  = ready_q;
  assign iob_rvalid_o = rvalid_q;
  assign iob_rdata_o  = rdata_q;
  assign apb_sel_o    = sel_q;
  assign apb_enable_o = en_q;
  assign apb_addr_o   = req_q.addr;
  assign apb_wdata_o  = req_q.wdata;
  assign apb_wstrb_o  = req_q.wstrb & {STRB_W{req_q.write}};
  assign apb_write_o  = req_q.write;

endmodule

// File: tb/tb_iob2apb.sv
// Self-checking bench for iob2apb: scenario tasks with inline checks
// and a read-data scoreboard queue.
module tb_iob2apb;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          cke;
  logic          arst_n;
  logic          valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          ready;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          psel;
  logic          pen;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pwrite;
  logic          pready;
  logic [DW-1:0] prdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp;

  always #5 clk = ~clk;

  iob2apb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk),
    .cke_i        (cke),
    .arst_n_i     (arst_n),
    .iob_valid_i  (valid),
    .iob_addr_i   (addr),
    .iob_wdata_i  (wdata),
    .iob_wstrb_i  (wstrb),
    .iob_ready_o  (ready),
    .iob_rvalid_o (rvalid),
    .iob_rdata_o  (rdata),
    .apb_sel_o    (psel),
    .apb_enable_o (pen),
    .apb_addr_o   (paddr),
    .apb_wdata_o  (pwdata),
    .apb_wstrb_o  (pstrb),
    .apb_write_o  (pwrite),
    .apb_ready_i  (pready),
    .apb_rdata_i  (prdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    cke    = 1'b1;
    valid  = 1'b0;
    addr   = '0;
    wdata  = '0;
    wstrb  = '0;
    pready = 1'b0;
    prdata = '0;
    tick();
    tick();
    n_cmp++;
    if ({psel, pen, pwrite, paddr, pwdata, pstrb} !== '0) begin
      n_err++;
      $display("FAIL rst_apb: got %b %b %b %h %h %h want all 0",
               psel, pen, pwrite, paddr, pwdata, pstrb);
    end
    n_cmp++;
    if ({ready, rvalid, rdata} !== '0) begin
      n_err++;
      $display("FAIL rst_iob: got rdy=%b rv=%b rd=%h want 0",
               ready, rvalid, rdata);
    end
    arst_n = 1'b1;
    #1;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rel_ready: got %b want 0 before edge", ready);
    end
    tick();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_first_edge_ready: got %b want 1", ready);
    end
  endtask

  task automatic test_write;
    valid = 1'b1;
    addr  = 21'h100;
    wdata = 32'hDEADBEEF;
    wstrb = 4'hF;
    tick();
    valid = 1'b0;
    n_cmp++;
    if ({psel, pen, ready, rvalid} !== 4'b1000) begin
      n_err++;
      $display("FAIL wr_c1_ctl: got sel/en/rdy/rv=%b want 1000",
               {psel, pen, ready, rvalid});
    end
    n_cmp++;
    if ({pwrite, pstrb, paddr, pwdata} !== {1'b1, 4'hF, 21'h100, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL wr_c1_bus: got w=%b s=%h a=%h d=%h want 1 f 100 deadbeef",
               pwrite, pstrb, paddr, pwdata);
    end
    tick();
    n_cmp++;
    if ({psel, pen, ready} !== 3'b110) begin
      n_err++;
      $display("FAIL wr_c2_ctl: got sel/en/rdy=%b want 110", {psel, pen, ready});
    end
    pready = 1'b1;
    tick();
    pready = 1'b0;
    n_cmp++;
    if ({psel, pen, ready, rvalid} !== 4'b0010) begin
      n_err++;
      $display("FAIL wr_c3_ctl: got sel/en/rdy/rv=%b want 0010",
               {psel, pen, ready, rvalid});
    end
  endtask

  task automatic test_read_wait;
    valid = 1'b1;
    addr  = 21'h2A4;
    wdata = 32'h5555AAAA;
    wstrb = 4'h0;
    exp_q.push_back(32'h12345678);
    tick();
    valid = 1'b0;
    addr  = 21'h1FFFF;
    n_cmp++;
    if ({psel, pen, pwrite, pstrb} !== {3'b100, 4'h0}) begin
      n_err++;
      $display("FAIL rd_setup: got sel/en/w=%b strb=%h want 100 0",
               {psel, pen, pwrite}, pstrb);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({psel, pen, ready, rvalid, paddr} !== {4'b1100, 21'h2A4}) begin
        n_err++;
        $display("FAIL rd_wait%0d: got ctl=%b addr=%h want 1100 2a4",
                 i, {psel, pen, ready, rvalid}, paddr);
      end
      tick();
    end
    pready = 1'b1;
    prdata = 32'h12345678;
    n_cmp++;
    if ({pen, paddr} !== {1'b1, 21'h2A4}) begin
      n_err++;
      $display("FAIL rd_acc4: got en=%b addr=%h want 1 2a4", pen, paddr);
    end
    tick();
    pready = 1'b0;
    prdata = 32'hFFFFFFFF;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    n_cmp++;
    if ({rvalid, ready, rdata} !== {2'b11, exp}) begin
      n_err++;
      $display("FAIL rd_resp: got rv=%b rdy=%b rd=%h want 1 1 %h",
               rvalid, ready, rdata, exp);
    end
    tick();
    n_cmp++;
    if ({rvalid, rdata} !== {1'b0, 32'h12345678}) begin
      n_err++;
      $display("FAIL rd_after: got rv=%b rd=%h want 0 12345678", rvalid, rdata);
    end
  endtask

  task automatic test_back_to_back;
    valid  = 1'b1;
    addr   = 21'h40;
    wdata  = 32'h0;
    wstrb  = 4'h0;
    pready = 1'b1;
    exp_q.push_back(32'hA5A50001);
    tick();
    n_cmp++;
    if ({psel, pen, pwrite, pstrb} !== {3'b100, 4'h0}) begin
      n_err++;
      $display("FAIL b2b_rd_setup: got sel/en/w=%b strb=%h want 100 0",
               {psel, pen, pwrite}, pstrb);
    end
    tick();
    prdata = 32'hA5A50001;
    addr   = 21'h44;
    wdata  = 32'hCAFEF00D;
    wstrb  = 4'h3;
    n_cmp++;
    if ({psel, pen, pstrb, paddr} !== {2'b11, 4'h0, 21'h40}) begin
      n_err++;
      $display("FAIL b2b_rd_access: got sel/en=%b strb=%h a=%h want 11 0 40",
               {psel, pen}, pstrb, paddr);
    end
    tick();
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    n_cmp++;
    if ({rvalid, ready, rdata} !== {2'b11, exp}) begin
      n_err++;
      $display("FAIL b2b_rd_resp: got rv=%b rdy=%b rd=%h want 1 1 %h",
               rvalid, ready, rdata, exp);
    end
    tick();
    valid = 1'b0;
    n_cmp++;
    if ({psel, pen, rvalid, pwrite, pstrb, paddr, pwdata} !==
        {4'b1001, 4'h3, 21'h44, 32'hCAFEF00D}) begin
      n_err++;
      $display("FAIL b2b_wr_setup: got ctl=%b s=%h a=%h d=%h want 1001 3 44 cafef00d",
               {psel, pen, rvalid, pwrite}, pstrb, paddr, pwdata);
    end
    tick();
    tick();
    pready = 1'b0;
    n_cmp++;
    if ({ready, rvalid, psel} !== 3'b100) begin
      n_err++;
      $display("FAIL b2b_wr_done: got rdy/rv/sel=%b want 100", {ready, rvalid, psel});
    end
  endtask

  task automatic test_partial_strobe;
    valid = 1'b1;
    addr  = 21'h80;
    wdata = 32'h00AB0000;
    wstrb = 4'h4;
    tick();
    valid = 1'b0;
    wdata = 32'hFFFFFFFF;
    wstrb = 4'hF;
    n_cmp++;
    if ({pwrite, pstrb, pwdata} !== {1'b1, 4'h4, 32'h00AB0000}) begin
      n_err++;
      $display("FAIL ps_setup: got w=%b s=%h d=%h want 1 4 00ab0000",
               pwrite, pstrb, pwdata);
    end
    tick();
    pready = 1'b1;
    n_cmp++;
    if ({pen, pstrb, pwdata} !== {1'b1, 4'h4, 32'h00AB0000}) begin
      n_err++;
      $display("FAIL ps_access: got en=%b s=%h d=%h want 1 4 00ab0000",
               pen, pstrb, pwdata);
    end
    tick();
    pready = 1'b0;
    n_cmp++;
    if ({ready, rvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL ps_done: got rdy/rv=%b want 10", {ready, rvalid});
    end
  endtask

  task automatic test_reset_mid;
    valid = 1'b1;
    addr  = 21'h300;
    wstrb = 4'h0;
    tick();
    valid = 1'b0;
    tick();
    tick();
    #2;
    arst_n = 1'b0;
    #1;
    n_cmp++;
    if ({psel, pen, rvalid, ready, paddr} !== '0) begin
      n_err++;
      $display("FAIL rm_async: got sel/en/rv/rdy=%b a=%h want 0",
               {psel, pen, rvalid, ready}, paddr);
    end
    #2;
    arst_n = 1'b1;
    tick();
    n_cmp++;
    if ({ready, rvalid} !== 2'b10) begin
      n_err++;
      $display("FAIL rm_release: got rdy/rv=%b want 10", {ready, rvalid});
    end
    valid  = 1'b1;
    addr   = 21'h304;
    pready = 1'b1;
    exp_q.push_back(32'h0BADCAFE);
    tick();
    valid = 1'b0;
    tick();
    prdata = 32'h0BADCAFE;
    tick();
    pready = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    n_cmp++;
    if ({rvalid, rdata} !== {1'b1, exp}) begin
      n_err++;
      $display("FAIL rm_new_read: got rv=%b rd=%h want 1 %h", rvalid, rdata, exp);
    end
  endtask

  task automatic test_cke_gating;
    tick();
    valid = 1'b1;
    addr  = 21'h10;
    wdata = 32'h11223344;
    wstrb = 4'hF;
    tick();
    valid = 1'b0;
    cke   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({psel, pen, ready} !== 3'b100) begin
        n_err++;
        $display("FAIL cke_setup%0d: got sel/en/rdy=%b want 100",
                 i, {psel, pen, ready});
      end
    end
    cke = 1'b1;
    tick();
    n_cmp++;
    if ({psel, pen, paddr} !== {2'b11, 21'h10}) begin
      n_err++;
      $display("FAIL cke_resume: got sel/en=%b a=%h want 11 10", {psel, pen}, paddr);
    end
    pready = 1'b1;
    tick();
    n_cmp++;
    if ({ready, psel, rvalid} !== 3'b100) begin
      n_err++;
      $display("FAIL cke_wr_done: got rdy/sel/rv=%b want 100", {ready, psel, rvalid});
    end
    valid = 1'b1;
    addr  = 21'h14;
    wstrb = 4'h0;
    exp_q.push_back(32'h77665544);
    tick();
    valid = 1'b0;
    tick();
    prdata = 32'h77665544;
    tick();
    pready = 1'b0;
    cke    = 1'b0;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({rvalid, rdata} !== {1'b1, exp}) begin
        n_err++;
        $display("FAIL cke_rv_hold%0d: got rv=%b rd=%h want 1 %h",
                 i, rvalid, rdata, exp);
      end
      tick();
    end
    cke = 1'b1;
    tick();
    n_cmp++;
    if (rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL cke_rv_end: got %b want 0", rvalid);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_partial_strobe();
    test_reset_mid();
    test_cke_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
